fifo_n: RTL and testbench
=========================

# fifo_n

Parametrised N-entry, W-bit guarded FIFO with method-style enq/deq/first interfaces. It replaces the fixed two-slot FIFO and differs from it in four ways: all DEPTH slots are usable, `first__RDY` is driven correctly, occupancy and almost-full status are exported, and a synchronous flush method is provided. It sits between producer and consumer modules in the lpm datapath wherever buffering deeper than two entries is needed.

## Interface
Parameters:
- WIDTH, 96: payload bits per entry; must be ≥1.
- DEPTH, 4: number of entries; must be ≥2 and need not be a power of two.
- AFULL_LEVEL, DEPTH-1: `almostFull` asserts when count ≥ AFULL_LEVEL; legal range is 1..DEPTH.

Ports (CW = clog2(DEPTH+1), PW = clog2(DEPTH)):
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in$enq__ENA  in  1  enqueue request.
- in$enq$v  in  WIDTH  enqueue payload.
- in$enq__RDY  out  1  enqueue allowed.
- out$deq__ENA  in  1  dequeue request.
- out$deq__RDY  out  1  dequeue allowed.
- out$first  out  WIDTH  head entry.
- out$first__RDY  out  1  `out$first` is valid.
- clear__ENA  in  1  flush request.
- clear__RDY  out  1  always 1.
- count  out  CW  current occupancy, 0..DEPTH.
- almostFull  out  1  count ≥ AFULL_LEVEL.

## Operation
- State:
  - rindex and windex, each PW bits, wrapping from DEPTH-1 to 0 with an explicit compare (no modulo).
  - count register, CW bits.
  - Storage array of DEPTH×WIDTH.
- Guards:
  - in$enq__RDY = (count != DEPTH).
  - out$deq__RDY = out$first__RDY = (count != 0).
- Enqueue fires when in$enq__ENA & in$enq__RDY: mem[windex] ← in$enq$v, windex advances.
- Dequeue fires when out$deq__ENA & out$deq__RDY: rindex advances.
- count update: +1 on enqueue only, −1 on dequeue only, unchanged when both fire or neither fires.
- Full FIFO with both ENAs high: only the dequeue fires. Enqueue is blocked because its RDY is 0; there is no pass-through.
- Empty FIFO with both ENAs high: only the enqueue fires. Dequeue is blocked; there is no bypass.
- out$first = mem[rindex] when count != 0, else all-zero. Never expose stale data.
- clear__ENA: rindex, windex and count go to 0 at the next edge. clear has priority over any enq or deq in the same cycle, and those requests are dropped. Storage contents are not cleared.
- ENA asserted while the corresponding RDY is 0 is ignored, with no state change. Producers are expected to gate ENA with RDY.

## Timing
- Reset (nRST low, asynchronous): rindex = windex = count = 0 immediately, without waiting for a clock edge. Storage is not reset.
- Output values while in reset and right after reset:
  - in$enq__RDY = 1
  - out$deq__RDY = 0
  - out$first__RDY = 0
  - out$first = 0
  - count = 0
  - almostFull = 0, or 1 only if AFULL_LEVEL = 0 (illegal)
  - clear__RDY = 1
- Reset deassertion is synchronised externally. The first enqueue is accepted on the first edge with nRST high.
- Latency from enqueue to out$first__RDY is 1 cycle: data written at edge k is visible at out$first after edge k.
- Sustained throughput is one enqueue and one dequeue per cycle whenever 0 < count < DEPTH.
- All RDY outputs and status outputs are decoded from registers only. None depends combinationally on any ENA input.

## Structure
- Package `fifo_n_pkg` holds:
  - a constant function clog2;
  - the derived widths PW and CW;
  - an elaboration check that DEPTH ≥ 2 and 1 ≤ AFULL_LEVEL ≤ DEPTH.
- One sub-module, `fifo_n_mem`: a DEPTH×WIDTH register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset.
- Pointer, count and guard logic live in the top level, fifo_n.

## Test plan
- Reset and fill: WIDTH=96, DEPTH=5, AFULL_LEVEL=4. Pulse nRST low mid-cycle; all outputs take their reset values with no clock edge. Enqueue 1..5 on consecutive cycles. Expect:
  - count steps 1..5;
  - almostFull rises after the 4th enqueue;
  - in$enq__RDY = 0 after the 5th;
  - out$first = 1 from the cycle after the first enqueue.
- Drain and wrap: continue from full, dequeue 5 times, then enqueue 6..8 and dequeue 3. Expect:
  - out$first sequence 1,2,3,4,5,6,7,8;
  - pointers wrap 4→0 correctly with non-power-of-two DEPTH;
  - out$first = 0 whenever count = 0.
- Simultaneous enq/deq: at count = 2, run 10 cycles with both ENAs high. Expect count held at 2 and in-order data throughout. At count = DEPTH with both high, only the dequeue occurs and count becomes DEPTH-1. At count = 0 with both high, only the enqueue occurs and count becomes 1.
- Clear: fill 3 entries, then assert clear__ENA together with in$enq__ENA and out$deq__ENA. Expect:
  - count = 0 at the next edge, out$first__RDY = 0, and the enqueued value lost;
  - the next enqueue of 0xABC appears as out$first = 0xABC.
- Illegal requests: assert in$enq__ENA while full and out$deq__ENA while empty. Expect no change in count, pointers or out$first.
- Reset mid-operation: with count = 3, drop nRST between edges. Expect count = 0 and out$first__RDY = 0 immediately, and the old data never reappears after refilling 1 entry.

Source files
------------

// File: rtl/fifo_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_n_pkg
//  Description : Shared helpers for the N-entry guarded FIFO. Provides width
//                derivation and the parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_n_pkg;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Read/write pointer width: addresses slots 0..DEPTH-1.
  function automatic int pw_of(input int depth);
    return clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int cw_of(input int depth);
    return clog2(depth + 1);
  endfunction

  // Legal configuration: at least one payload bit, two or more slots,
  // and an almost-full threshold inside 1..DEPTH.
  function automatic bit params_ok(input int width, input int depth, input int afull_level);
    return (width >= 1) && (depth >= 2) && (afull_level >= 1) && (afull_level <= depth);
  endfunction

endpackage : fifo_n_pkg
`default_nettype wire

// File: rtl/fifo_n_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_n_mem
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one asynchronous read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_n_mem #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed slot on an accepted enqueue.
  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Combinational read so the head entry is visible the cycle after it lands.
  always_comb begin
    rdata = r_mem[raddr];
  end

endmodule : fifo_n_mem
`default_nettype wire

// File: rtl/fifo_n.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_n
//  Description : Parametrised N-entry guarded FIFO with enq/deq/first method
//                interfaces, occupancy and almost-full status, and a
//                synchronous flush. All DEPTH slots are usable; no bypass and
//                no pass-through paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_n
  import fifo_n_pkg::*;
#(
  parameter int WIDTH       = 96,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      in_enq__ENA,
  input  logic [WIDTH-1:0]          in_enq_v,
  output logic                      in_enq__RDY,
  input  logic                      out_deq__ENA,
  output logic                      out_deq__RDY,
  output logic [WIDTH-1:0]          out_first,
  output logic                      out_first__RDY,
  input  logic                      clear__ENA,
  output logic                      clear__RDY,
  output logic [cw_of(DEPTH)-1:0]   count,
  output logic                      almostFull
);

  localparam int PW = pw_of(DEPTH);
  localparam int CW = cw_of(DEPTH);

  localparam logic [CW-1:0] c_full_count  = CW'(DEPTH);
  localparam logic [CW-1:0] c_afull_count = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] c_cnt_one     = CW'(1);
  localparam logic [PW-1:0] c_last_ptr    = PW'(DEPTH - 1);
  localparam logic [PW-1:0] c_ptr_one     = PW'(1);

  // Refuse to elaborate an unusable configuration.
  if (!params_ok(WIDTH, DEPTH, AFULL_LEVEL)) begin : g_param_check
    $error("fifo_n: illegal parameters WIDTH=%0d DEPTH=%0d AFULL_LEVEL=%0d",
           WIDTH, DEPTH, AFULL_LEVEL);
  end

  logic [PW-1:0]    r_rindex;
  logic [PW-1:0]    r_windex;
  logic [CW-1:0]    r_count;

  logic             w_not_full;
  logic             w_not_empty;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [PW-1:0]    w_rindex_nxt;
  logic [PW-1:0]    w_windex_nxt;
  logic [WIDTH-1:0] w_head;

  // Guards come from the count register only, never from any ENA.
  always_comb begin
    w_not_full  = (r_count != c_full_count);
    w_not_empty = (r_count != '0);
  end

  // A method fires only when requested and guarded; clear drops both.
  always_comb begin
    w_enq_fire = in_enq__ENA  & w_not_full  & ~clear__ENA;
    w_deq_fire = out_deq__ENA & w_not_empty & ~clear__ENA;
  end

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  always_comb begin
    w_rindex_nxt = (r_rindex == c_last_ptr) ? '0 : (r_rindex + c_ptr_one);
    w_windex_nxt = (r_windex == c_last_ptr) ? '0 : (r_windex + c_ptr_one);
  end

  // Pointer and occupancy state; clear wins over enq/deq in the same cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rindex <= '0;
      r_windex <= '0;
      r_count  <= '0;
    end else if (clear__ENA) begin
      r_rindex <= '0;
      r_windex <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) begin
        r_windex <= w_windex_nxt;
      end
      if (w_deq_fire) begin
        r_rindex <= w_rindex_nxt;
      end
      if (w_enq_fire && !w_deq_fire) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_deq_fire && !w_enq_fire) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  fifo_n_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .CLK   (CLK),
    .we    (w_enq_fire),
    .waddr (r_windex),
    .wdata (in_enq_v),
    .raddr (r_rindex),
    .rdata (w_head)
  );

  // Outputs: head is masked to zero when empty so stale data never leaks.
  always_comb begin
    in_enq__RDY    = w_not_full;
    out_deq__RDY   = w_not_empty;
    out_first__RDY = w_not_empty;
    out_first      = w_not_empty ? w_head : '0;
    clear__RDY     = 1'b1;
    count          = r_count;
    almostFull     = (r_count >= c_afull_count);
  end

endmodule : fifo_n
`default_nettype wire

// File: tb/tb_fifo_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_n
//  Description : Directed self-checking bench for fifo_n (WIDTH=96, DEPTH=5,
//                AFULL_LEVEL=4) with a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_n;

  localparam int WIDTH       = 96;
  localparam int DEPTH       = 5;
  localparam int AFULL_LEVEL = 4;
  localparam int CW          = 3;

  logic             CLK;
  logic             nRST;
  logic             in_enq__ENA;
  logic [WIDTH-1:0] in_enq_v;
  logic             in_enq__RDY;
  logic             out_deq__ENA;
  logic             out_deq__RDY;
  logic [WIDTH-1:0] out_first;
  logic             out_first__RDY;
  logic             clear__ENA;
  logic             clear__RDY;
  logic [CW-1:0]    count;
  logic             almostFull;

  logic [WIDTH-1:0] sb_q[$];
  int               n_cmp;
  int               n_bad;

  fifo_n #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .in_enq__ENA    (in_enq__ENA),
    .in_enq_v       (in_enq_v),
    .in_enq__RDY    (in_enq__RDY),
    .out_deq__ENA   (out_deq__ENA),
    .out_deq__RDY   (out_deq__RDY),
    .out_first      (out_first),
    .out_first__RDY (out_first__RDY),
    .clear__ENA     (clear__ENA),
    .clear__RDY     (clear__RDY),
    .count          (count),
    .almostFull     (almostFull)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard's view of the FIFO.
  task automatic check_state(input string where);
    int unsigned n;
    logic [WIDTH-1:0] exp_first;
    n = sb_q.size();
    exp_first = (n != 0) ? sb_q[0] : '0;
    chk({where, ".count"},       WIDTH'(count),          WIDTH'(n));
    chk({where, ".enq_rdy"},     WIDTH'(in_enq__RDY),    WIDTH'(n != DEPTH));
    chk({where, ".deq_rdy"},     WIDTH'(out_deq__RDY),   WIDTH'(n != 0));
    chk({where, ".first_rdy"},   WIDTH'(out_first__RDY), WIDTH'(n != 0));
    chk({where, ".first"},       out_first,              exp_first);
    chk({where, ".almost_full"}, WIDTH'(almostFull),     WIDTH'(n >= AFULL_LEVEL));
    chk({where, ".clear_rdy"},   WIDTH'(clear__RDY),     WIDTH'(1));
  endtask

  // One clock cycle of requests; called between edges.
  task automatic cycle(input string where, input bit enq, input logic [WIDTH-1:0] v,
                       input bit deq, input bit clr);
    bit enq_ok;
    bit deq_ok;
    logic [WIDTH-1:0] popped;
    in_enq__ENA  = enq;
    in_enq_v     = v;
    out_deq__ENA = deq;
    clear__ENA   = clr;
    enq_ok = enq && (sb_q.size() < DEPTH) && !clr;
    deq_ok = deq && (sb_q.size() > 0) && !clr;
    #1;
    if (deq_ok) begin
      popped = sb_q.pop_front();
      chk({where, ".deq_data"}, out_first, popped);
    end
    @(posedge CLK);
    if (clr) sb_q.delete();
    if (enq_ok) sb_q.push_back(v);
    #1;
    in_enq__ENA  = 1'b0;
    out_deq__ENA = 1'b0;
    clear__ENA   = 1'b0;
    check_state(where);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST         = 1'b1;
    in_enq__ENA  = 1'b0;
    in_enq_v     = '0;
    out_deq__ENA = 1'b0;
    clear__ENA   = 1'b0;

    // Reset asserted between edges must act without a clock.
    #2 nRST = 1'b0;
    #1 check_state("reset_async");
    @(posedge CLK);
    @(posedge CLK);
    #1 check_state("reset_held");
    #2 nRST = 1'b1;

    // Fill 1..5; first enqueue lands on the first edge after release.
    for (int i = 1; i <= 5; i++) cycle("fill", 1'b1, WIDTH'(i), 1'b0, 1'b0);

    // Drain, then wrap both pointers with 6..8.
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 6; i <= 8; i++) cycle("wrap_enq", 1'b1, WIDTH'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("wrap_deq", 1'b0, '0, 1'b1, 1'b0);

    // Steady state at count=2 with both methods every cycle.
    cycle("pre2", 1'b1, {32'hA5A5_0001, 32'h0F0F_F0F0, 32'h0000_0009}, 1'b0, 1'b0);
    cycle("pre2", 1'b1, {32'hA5A5_0002, 32'hF0F0_0F0F, 32'h0000_000A}, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle("both_mid", 1'b1, {32'(i * 7 + 1), 32'hDEAD_0000 | 32'(i), 32'($urandom)}, 1'b1, 1'b0);

    // Full with both requests: only the dequeue happens.
    for (int i = 0; i < 3; i++) cycle("fill_full", 1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
    cycle("both_full", 1'b1, WIDTH'(96'h1234), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("empty_out", 1'b0, '0, 1'b1, 1'b0);

    // Empty with both requests: only the enqueue happens.
    cycle("both_empty", 1'b1, WIDTH'(96'h5678), 1'b1, 1'b0);
    cycle("both_empty_deq", 1'b0, '0, 1'b1, 1'b0);

    // Clear beats simultaneous enq and deq; storage reuse after clear.
    for (int i = 0; i < 3; i++) cycle("pre_clear", 1'b1, WIDTH'(200 + i), 1'b0, 1'b0);
    cycle("clear", 1'b1, WIDTH'(96'h555), 1'b1, 1'b1);
    cycle("post_clear", 1'b1, WIDTH'(96'hABC), 1'b0, 1'b0);
    cycle("post_clear_deq", 1'b0, '0, 1'b1, 1'b0);

    // Requests against a closed guard must be ignored.
    for (int i = 0; i < 5; i++) cycle("ill_fill", 1'b1, WIDTH'(300 + i), 1'b0, 1'b0);
    cycle("enq_when_full", 1'b1, WIDTH'(96'hDEAD), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("ill_drain", 1'b0, '0, 1'b1, 1'b0);
    cycle("deq_when_empty", 1'b0, '0, 1'b1, 1'b0);
    cycle("after_ill", 1'b1, WIDTH'(96'hBEEF), 1'b0, 1'b0);
    cycle("after_ill_deq", 1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation with three entries held.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, WIDTH'(400 + i), 1'b0, 1'b0);
    #2 nRST = 1'b0;
    sb_q.delete();
    #1 check_state("mid_reset");
    @(posedge CLK);
    #3 nRST = 1'b1;
    cycle("refill", 1'b1, WIDTH'(96'h77), 1'b0, 1'b0);
    cycle("refill_deq", 1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fifo_n
`default_nettype wire
